// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM states.
// Also imported by the ALU control decoder, so keep the code values stable.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: start loads operands, then one bit per cycle for WIDTH cycles.
// done flags the final step; product is the accumulator value that step produces (low WIDTH bits).
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  // Fixed latency: no early exit even when the multiplier runs out of ones.
  assign product = acc_d;
  assign done    = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_exec.sv
// Registered execute ALU: logic/add/sub/slt in one cycle; mul takes WIDTH cycles with ready_o low.
// Build option ALU_EXEC_MUL_EN enables the multiplier; otherwise code 011 acts as reserved.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [2:0]       gout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             zero_q;
  logic             done_q;

  // Signed compare directly, so slt stays correct when a-b overflows.
  always_comb begin
    result_d = '0;
    case (gout)
      ALU_ADD: result_d = a + b;
      ALU_SUB: result_d = a - b;
      ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_OR:  result_d = a | b;
      ALU_NOR: result_d = ~(a | b);
      ALU_AND: result_d = a & b;
      default: result_d = '0;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  alu_state_e       state_q;
  logic             mul_start;
  logic             mul_last;
  logic [WIDTH-1:0] mul_prod;

  assign mul_start = valid_i && (state_q == IDLE) && (gout == ALU_MUL);

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .product (mul_prod),
    .done    (mul_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (gout == ALU_MUL) begin
              state_q <= MUL;
            end else begin
              result_q <= result_d;
              zero_q   <= (result_d == '0);
              done_q   <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_last) begin
            result_q <= mul_prod;
            zero_q   <= (mul_prod == '0);
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == MUL);
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= valid_i;
      if (valid_i) begin
        result_q <= result_d;
        zero_q   <= (result_d == '0);
      end
    end
  end

  assign ready_o = 1'b1;
  assign busy_o  = 1'b0;
`endif

  assign result = result_q;
  assign zero   = zero_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec; covers both builds of ALU_EXEC_MUL_EN.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_EXEC_MUL_EN
  localparam int MUL_LAT = W;
`else
  localparam int MUL_LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic [2:0]   gout = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result;
  logic         zero;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    int           cyc;
  } exp_t;

  exp_t         sbq[$];
  exp_t         e_mon;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic         rst_seen = 1'b0;
  logic [W-1:0] hold_res = '0;
  logic         hold_zero = 1'b1;

  alu_exec #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .gout    (gout),
    .a       (a),
    .b       (b),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result  (result),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] c, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    case (c)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x + ~y + 1'b1;
      ALU_SLT: r[0] = (x[W-1] != y[W-1]) ? x[W-1] : (x < y);
      ALU_OR:  r = x | y;
      ALU_NOR: r = ~(x | y);
      ALU_AND: r = x & y;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drive one request for one edge; when do_push, queue the expected completion.
  task automatic issue(input logic [2:0] code, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] exp, input int lat, input bit do_push);
    exp_t e;
    valid_i = 1'b1;
    gout    = code;
    a       = av;
    b       = bv;
    if (do_push) begin
      e.res  = exp;
      e.zero = (exp == '0);
      e.cyc  = cyc + 1 + lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_seen) begin
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_done", done_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        hold_res  = '0;
        hold_zero = 1'b1;
      end else if (done_o) begin
        if (sbq.size() == 0) begin
          check("spurious_done", done_o, 0);
        end else begin
          e_mon = sbq.pop_front();
          check("result", result, e_mon.res);
          check("zero", zero, e_mon.zero);
          check("done_cycle", cyc, e_mon.cyc);
          hold_res  = e_mon.res;
          hold_zero = e_mon.zero;
        end
      end else begin
        check("hold_result", result, hold_res);
        check("hold_zero", zero, hold_zero);
      end
`ifndef ALU_EXEC_MUL_EN
      check("ready_tied", ready_o, 1);
      check("busy_tied", busy_o, 0);
`endif
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   codes[6];
    logic [2:0]   c;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    int           e0;
    codes = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_OR, ALU_NOR, ALU_AND};

    // Reset held with a pending request that must be ignored.
    rst_n = 1'b0; valid_i = 1'b1; gout = ALU_ADD; a = 32'd1; b = 32'd1;
    idle(3);
    rst_n = 1'b1; valid_i = 1'b0;
    idle(1);

    issue(ALU_ADD, 32'd7, 32'd5, 32'd12, 0, 1'b1);
    issue(ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1'b1);
    issue(ALU_SLT, 32'h8000_0000, 32'd1, 32'd1, 0, 1'b1);
    issue(ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
    issue(ALU_AND, 32'hF0, 32'h3C, 32'h30, 0, 1'b1);
    issue(ALU_SLT, 32'd1, 32'h8000_0000, 32'd0, 0, 1'b1);
    issue(ALU_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 1'b1);
    issue(3'b101, 32'd9, 32'd9, 32'd0, 0, 1'b1);
    idle(2);

    for (int i = 0; i < 12; i++) begin
      c  = codes[$urandom_range(0, 5)];
      av = $urandom;
      bv = (i == 3) ? av : $urandom;
      issue(c, av, bv, model(c, av, bv), 0, 1'b1);
    end
    idle(2);

`ifdef ALU_EXEC_MUL_EN
    // mul with a competing add held high throughout; add lands on the done cycle.
    valid_i = 1'b1; gout = ALU_MUL; a = 32'h1234; b = 32'h10;
    begin
      exp_t em;
      em.res = 32'h12340; em.zero = 1'b0; em.cyc = cyc + 1 + MUL_LAT;
      sbq.push_back(em);
    end
    @(posedge clk);
    #1;
    e0 = cyc;
    gout = ALU_ADD; a = 32'd1; b = 32'd1;
    begin
      exp_t ea;
      ea.res = 32'd2; ea.zero = 1'b0; ea.cyc = e0 + W + 1;
      sbq.push_back(ea);
    end
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      check("mul_ready", ready_o, (k == W) ? 1 : 0);
      check("mul_busy", busy_o, (k == W) ? 0 : 1);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    idle(2);

    issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MUL_LAT, 1'b1);
    idle(W + 1);
    issue(ALU_MUL, 32'd5, 32'd0, 32'd0, MUL_LAT, 1'b1);
    idle(W + 1);
    issue(ALU_MUL, 32'd3, 32'd7, 32'd21, MUL_LAT, 1'b1);
    idle(W + 1);

    // Abort: reset lands on the tenth edge of the multiply.
    issue(ALU_MUL, 32'h1234, 32'h5678, 32'd0, MUL_LAT, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", ready_o, 1);
    check("abort_result", result, 0);
    @(posedge clk);
    #1;
    issue(ALU_OR, 32'd1, 32'd2, 32'd3, 0, 1'b1);
    idle(W + 4);
`else
    issue(ALU_MUL, 32'd3, 32'd4, 32'd0, MUL_LAT, 1'b1);
    issue(ALU_ADD, 32'd3, 32'd4, 32'd7, 0, 1'b1);
    issue(ALU_MUL, 32'd3, 32'd4, 32'd0, MUL_LAT, 1'b1);
    idle(2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    issue(ALU_OR, 32'd1, 32'd2, 32'd3, 0, 1'b1);
    idle(2);
`endif

    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
